// File: rtl/life_board_loader.sv
// life_board_loader: gathers row beats into a shadow board and commits whole frames to the board updater
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   row beat handshake; in_row bit i = column i, in_last marks the final row
//   load, data          one-cycle commit strobe and the committed board image (held between commits)
//   err                 one-cycle pulse when a frame is too short or too long
//   frame_cnt           number of committed frames, wrapping at 16 bits
module life_board_loader #(
  parameter int WIDTH     = 16,
  parameter int HEIGHT    = 16,
  parameter int FULLWIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_row,
  input  logic                 in_last,
  output logic                 load,
  output logic [FULLWIDTH-1:0] data,
  output logic                 err,
  output logic [15:0]          frame_cnt
);
  localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam logic [RW-1:0] LAST = RW'(HEIGHT - 1);
  typedef enum logic [1:0] {FILL, COMMIT, DRAIN} state_t;
  state_t state, state_n;
  logic [RW-1:0] r, r_n;
  logic [FULLWIDTH-1:0] shadow, shadow_w;
  logic [15:0] cnt_n;
  logic acc, load_n, err_n;
  assign in_ready = rst_n && state != COMMIT;
  assign acc = in_valid && in_ready;
  // shadow with the current row replaced; also the image committed on the final beat
  always_comb begin
    shadow_w = shadow;
    for (int h = 0; h < HEIGHT; h++)
      if (RW'(h) == r) shadow_w[h*WIDTH +: WIDTH] = in_row;
  end
  always_comb begin
    state_n = state;
    r_n = r;
    load_n = 1'b0;
    err_n = 1'b0;
    cnt_n = frame_cnt;
    case (state)
      FILL: if (acc) begin
        r_n = (r == LAST || in_last) ? '0 : r + RW'(1);
        load_n = r == LAST && in_last;
        err_n = (r == LAST) != in_last;
        state_n = r != LAST ? FILL : in_last ? COMMIT : DRAIN;
      end
      COMMIT: begin
        state_n = FILL;
        cnt_n = frame_cnt + 16'd1;
      end
      default: state_n = (acc && in_last) ? FILL : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FILL;
      r <= '0;
      load <= 1'b0;
      err <= 1'b0;
      data <= '0;
      shadow <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      r <= r_n;
      load <= load_n;
      err <= err_n;
      frame_cnt <= cnt_n;
      if (acc && state == FILL) shadow <= shadow_w;
      if (load_n) data <= shadow_w;
    end
endmodule

// File: tb/tb_life_board_loader.sv
// tb_life_board_loader: directed checks of the row loader on a 4x3 board
module tb_life_board_loader;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [3:0] in_row = '0;
  logic in_ready, load, err;
  logic [11:0] data;
  logic [15:0] frame_cnt;
  int checks = 0, failures = 0;
  life_board_loader #(.WIDTH(4), .HEIGHT(3), .FULLWIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .in_last(in_last), .load(load), .data(data), .err(err), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [3:0] row, input logic last);
    in_valid = 1'b1;
    in_row = row;
    in_last = last;
    tick();
    in_valid = 1'b0;
    in_row = 4'hx;
    in_last = 1'bx;
  endtask
  initial begin
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_load", load, 0);
    chk("rst_err", err, 0);
    chk("rst_data", data, 0);
    chk("rst_cnt", frame_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready", in_ready, 1);
    put(4'h7, 0); put(4'h1, 0); put(4'h2, 1);
    chk("f1_load", load, 1);
    chk("f1_data", data, 12'h217);
    chk("f1_ready_commit", in_ready, 0);
    chk("f1_err", err, 0);
    chk("f1_cnt_before", frame_cnt, 0);
    tick();
    chk("f1_load_off", load, 0);
    chk("f1_cnt", frame_cnt, 1);
    chk("f1_ready_back", in_ready, 1);
    put(4'hF, 0); put(4'hF, 1);
    chk("short_err", err, 1);
    chk("short_load", load, 0);
    tick();
    chk("short_err_off", err, 0);
    chk("short_data", data, 12'h217);
    chk("short_cnt", frame_cnt, 1);
    put(4'h1, 0); put(4'h0, 0); put(4'h8, 1);
    chk("f2_load", load, 1);
    chk("f2_data", data, 12'h801);
    tick();
    chk("f2_cnt", frame_cnt, 2);
    put(4'h3, 0); put(4'h3, 0); put(4'h3, 0);
    chk("long_err", err, 1);
    chk("long_load", load, 0);
    put(4'h3, 0);
    chk("drain_err_off", err, 0);
    chk("drain_ready", in_ready, 1);
    put(4'h5, 1);
    chk("drain_end_err", err, 0);
    chk("drain_end_load", load, 0);
    chk("drain_data", data, 12'h801);
    put(4'h4, 0); put(4'h5, 0); put(4'h6, 1);
    chk("f3_load", load, 1);
    chk("f3_data", data, 12'h654);
    tick();
    chk("f3_cnt", frame_cnt, 3);
    put(4'h9, 0); tick(); put(4'hA, 0); tick(); put(4'hB, 1);
    chk("gap_load", load, 1);
    chk("gap_data", data, 12'hBA9);
    in_valid = 1'b1;
    in_row = 4'hC;
    in_last = 1'b0;
    chk("commit_ready", in_ready, 0);
    tick();
    chk("held_load_off", load, 0);
    chk("held_cnt", frame_cnt, 4);
    chk("held_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("held_err", err, 0);
    put(4'hD, 0); put(4'hE, 1);
    chk("held_load", load, 1);
    chk("held_data", data, 12'hEDC);
    tick();
    chk("held_cnt2", frame_cnt, 5);
    put(4'h1, 0); put(4'h2, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_load", load, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    tick();
    put(4'hA, 0); put(4'hB, 0); put(4'hC, 1);
    chk("post_rst_load", load, 1);
    chk("post_rst_data", data, 12'hCBA);
    rst_n = 1'b0;
    #1;
    chk("commit_rst_load", load, 0);
    chk("commit_rst_data", data, 0);
    chk("commit_rst_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    tick();
    force dut.frame_cnt = 16'hFFFE;
    #1;
    release dut.frame_cnt;
    tick();
    put(4'h1, 0); put(4'h2, 0); put(4'h3, 1);
    chk("wrap_data", data, 12'h321);
    tick();
    chk("cnt_ffff", frame_cnt, 16'hFFFF);
    put(4'h4, 0); put(4'h2, 0); put(4'h1, 1);
    tick();
    chk("cnt_wrap", frame_cnt, 0);
    chk("wrap_data2", data, 12'h124);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  always @(negedge clk)
    if (rst_n && load && err) begin
      failures++;
      $display("FAIL load_err_overlap load=%0b err=%0b required not both 1", load, err);
    end
endmodule

// File: doc/life_board_loader.md
LIFE_BOARD_LOADER -- requirements
Module: life_board_loader

Interface
REQ-001 Parameter WIDTH, default 16, board columns (cells per row).
REQ-002 Parameter HEIGHT, default 16, board rows.
REQ-003 Parameter FULLWIDTH, default 256, board bits; SHALL equal WIDTH*HEIGHT.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream row beat valid.
REQ-007 in_ready  output  1  loader accepts a beat this cycle.
REQ-008 in_row  input  WIDTH  one board row; bit i = column i.
REQ-009 in_last  input  1  marks final row beat of a frame.
REQ-010 load  output  1  one-cycle commit strobe to the board updater's load input.
REQ-011 data  output  FULLWIDTH  committed board image to the board updater's data input.
REQ-012 err  output  1  one-cycle pulse on malformed frame.
REQ-013 frame_cnt  output  16  count of committed frames.

Function
REQ-014 A beat SHALL be accepted on a posedge where in_valid=1 and in_ready=1; no other beat has effect.
REQ-015 States SHALL be FILL, COMMIT, DRAIN.
REQ-016 in_ready SHALL be 1 in FILL and DRAIN, 0 in COMMIT, and 0 while rst_n=0.
REQ-017 FILL: row counter r (0..HEIGHT-1); accepted beat k of a frame SHALL write shadow[k*WIDTH+i] = in_row[i] for all i.
REQ-018 FILL, beat accepted with r=HEIGHT-1 and in_last=1: go to COMMIT, r <= 0.
REQ-019 FILL, beat accepted with r<HEIGHT-1 and in_last=0: r <= r+1, stay FILL.
REQ-020 FILL, beat accepted with r<HEIGHT-1 and in_last=1 (short frame): err=1 next cycle, r <= 0, stay FILL, no commit.
REQ-021 FILL, beat accepted with r=HEIGHT-1 and in_last=0 (long frame): err=1 next cycle, r <= 0, go to DRAIN, no commit.
REQ-022 DRAIN: accepted beats discarded; accepted beat with in_last=1 returns to FILL with r=0; no further err pulses.
REQ-023 COMMIT lasts exactly one cycle: load=1, data = full shadow image that same cycle, frame_cnt incremented at its closing edge; then FILL.
REQ-024 Latency: final beat accepted at edge N -> load=1 in cycle N..N+1; first beat of the next frame acceptable at edge N+2 at the earliest.
REQ-025 data SHALL change only on entry to COMMIT and hold its value otherwise, including across errors and partial frames.
REQ-026 Aborted frames SHALL not alter data; the shadow image of an aborted frame is overwritten row by row by the next frame.
REQ-027 frame_cnt SHALL wrap 16'hFFFF -> 16'h0000.
REQ-028 load and err SHALL be registered outputs and never both 1 in the same cycle.
REQ-029 in_row/in_last values on non-accepted cycles SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force state FILL, r=0, load=0, err=0, data=0, shadow=0, frame_cnt=0.
REQ-031 Reset mid-frame or in DRAIN SHALL discard the partial frame; the first beat accepted after release is row 0.
REQ-032 Reset asserted during COMMIT SHALL force load=0 immediately; data and frame_cnt return to 0.

Verification (WIDTH=4, HEIGHT=3, FULLWIDTH=12)
REQ-033 Rows 4'h7,4'h1,4'h2 back-to-back, in_last on third -> load=1 for one cycle one cycle later, data=12'h217, frame_cnt=1, in_ready=0 during that cycle only.
REQ-034 Rows 4'hF,4'hF with in_last on second -> err one cycle, no load, data stays 12'h217; next good frame 4'h1,4'h0,4'h8 -> data=12'h801, frame_cnt=2.
REQ-035 Four beats 4'h3 with no in_last, then 4'h5 with in_last -> err once after third beat, all five beats accepted, no load, then FILL with r=0.
REQ-036 Good frame with in_valid toggling 1-0-1-0-1 and one beat presented during COMMIT -> no beat lost or duplicated, committed data matches rows.
REQ-037 rst_n pulsed low after two rows of a frame -> all outputs 0; subsequent rows 4'hA,4'hB,4'hC -> data=12'hCBA.
REQ-038 frame_cnt preloaded by 65535 good frames -> next commit wraps it to 0.
